// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults for the SPI slave.
package spi_pkg;
    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 3;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchronizer with registered rise/fall detection.
module spi_sync_edge import spi_pkg::*; #(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              last;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync <= {STAGES{RST_VAL}};
            last <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            last <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~last;
    assign fall = ~sync[STAGES-1] & last;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave, oversampled in sys_clk, byte strobes to the core.
module spi_slave import spi_pkg::*; #(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    input  logic              ssel,
    output logic              byte_received,
    output logic [DATA_W-1:0] received_data,
    output logic              data_needed,
    input  logic [DATA_W-1:0] data_to_send
);
    localparam int            CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] mosiPipe;
    logic                   sckRise, sckFall, sselStart, sselEnd;
    logic                   selected, selNext;
    logic [CW-1:0]          bitCnt;
    logic [DATA_W-1:0]      rxShift, rxNext, txShift, txNext;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) sckEdge (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(sck), .rise(sckRise), .fall(sckFall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) sselEdge (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(ssel), .rise(sselEnd), .fall(sselStart)
    );

    // selected lags the ssel edge by one cycle, so a final rise coincident with
    // ssel_end still sees the frame as active and completes the word.
    always_comb begin
        rxNext  = {rxShift[DATA_W-2:0], mosiPipe[SYNC_STAGES-1]};
        selNext = sselStart | (selected & ~sselEnd);
        txNext  = sselStart ? data_to_send :
                  (sckFall && selected) ? ((bitCnt == '0) ? data_to_send : txShift << 1) :
                  txShift;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mosiPipe      <= '0;
            selected      <= 1'b0;
            bitCnt        <= '0;
            rxShift       <= '0;
            txShift       <= '0;
            miso          <= 1'b0;
            received_data <= '0;
            byte_received <= 1'b0;
            data_needed   <= 1'b0;
        end else begin
            mosiPipe      <= {mosiPipe[SYNC_STAGES-2:0], mosi};
            selected      <= selNext;
            txShift       <= txNext;
            miso          <= selNext & txNext[DATA_W-1];
            byte_received <= 1'b0;
            data_needed   <= 1'b0;
            if (sselStart) begin
                bitCnt <= '0;
            end else if (sckRise && selected) begin
                rxShift <= rxNext;
                bitCnt  <= (bitCnt == LAST) ? '0 : bitCnt + 1'b1;
                if (bitCnt == LAST) begin
                    received_data <= rxNext;
                    byte_received <= 1'b1;
                    data_needed   <= 1'b1;
                end
            end
            if (sselEnd)
                bitCnt <= '0;
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master with a received-byte scoreboard and strobe checks.
module tb_spi_slave;
    logic       sys_clk = 1'b0;
    logic       sys_rst, sck, mosi, ssel;
    logic       miso, byte_received, data_needed;
    logic [7:0] received_data, data_to_send, got;
    logic [7:0] rxQ[$];
    int         checks = 0, errors = 0, brCount = 0, dnCount = 0;
    logic       prevBr = 1'b0, prevDn = 1'b0;

    always #1 sys_clk = ~sys_clk;

    spi_slave dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sck(sck), .mosi(mosi), .miso(miso),
        .ssel(ssel), .byte_received(byte_received), .received_data(received_data),
        .data_needed(data_needed), .data_to_send(data_to_send)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sys_clk step; strobes are checked against the scoreboard every cycle.
    task automatic tick();
        @(negedge sys_clk);
        if (byte_received || data_needed)
            chk("strobe pair", data_needed, byte_received);
        if (byte_received) begin
            chk("byte_received width", prevBr, 0);
            chk("unexpected byte_received", rxQ.size() > 0, 1);
            if (rxQ.size() > 0)
                chk("received_data", received_data, rxQ.pop_front());
            brCount++;
        end
        if (data_needed) begin
            chk("data_needed width", prevDn, 0);
            dnCount++;
        end
        prevBr = byte_received;
        prevDn = data_needed;
    endtask

    task automatic waitT(input int n);
        repeat (n) tick();
    endtask

    // Mode 0 master: drive mosi while sck low, sample miso on the rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, input logic [7:0] nextLoad,
                        output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            waitT(5);
            sck   = 1'b1;
            rx[i] = miso;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (i == 0 && data_needed)
                    data_to_send = nextLoad;
            end
            sck = 1'b0;
        end
    endtask

    task automatic startFrame();
        ssel = 1'b0;
        waitT(5);
    endtask

    task automatic endFrame();
        waitT(5);
        ssel = 1'b1;
        waitT(10);
    endtask

    initial begin
        sys_rst = 1'b1; sck = 1'b0; mosi = 1'b0; ssel = 1'b1; data_to_send = 8'h00;
        waitT(5);
        chk("reset miso", miso, 0);
        chk("reset byte_received", byte_received, 0);
        chk("reset data_needed", data_needed, 0);
        chk("reset received_data", received_data, 0);
        sys_rst = 1'b0;
        waitT(5);

        data_to_send = 8'h5A;
        rxQ.push_back(8'hA5);
        startFrame();
        xfer(8'hA5, 8, 8'h5A, got);
        chk("single miso", got, 8'h5A);
        endFrame();
        chk("single br count", brCount, 1);
        chk("single dn count", dnCount, 1);
        chk("single received_data", received_data, 8'hA5);

        data_to_send = 8'h5A;
        rxQ.push_back(8'hA5);
        rxQ.push_back(8'h0F);
        startFrame();
        xfer(8'hA5, 8, 8'h3C, got);
        chk("b2b miso 1", got, 8'h5A);
        xfer(8'h0F, 8, 8'h3C, got);
        chk("b2b miso 2", got, 8'h3C);
        endFrame();
        chk("b2b br count", brCount, 3);
        chk("b2b dn count", dnCount, 3);

        data_to_send = 8'hE7;
        startFrame();
        xfer(8'hFF, 5, 8'hE7, got);
        endFrame();
        chk("partial no strobe", brCount, 3);
        chk("partial keeps data", received_data, 8'h0F);
        chk("deselected miso", miso, 0);
        data_to_send = 8'h99;
        rxQ.push_back(8'h81);
        startFrame();
        xfer(8'h81, 8, 8'h99, got);
        chk("after partial miso", got, 8'h99);
        endFrame();
        chk("after partial br count", brCount, 4);

        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom);
            sck  = 1'b1;
            waitT(5);
            chk("idle miso", miso, 0);
            sck = 1'b0;
            waitT(5);
        end
        chk("idle br count", brCount, 4);
        chk("idle dn count", dnCount, 4);
        chk("idle received_data", received_data, 8'h81);

        data_to_send = 8'h77;
        startFrame();
        xfer(8'hFF, 4, 8'h77, got);
        sys_rst = 1'b1;
        waitT(3);
        chk("midreset miso", miso, 0);
        chk("midreset byte_received", byte_received, 0);
        chk("midreset data_needed", data_needed, 0);
        chk("midreset received_data", received_data, 0);
        ssel = 1'b1; mosi = 1'b0;
        waitT(5);
        sys_rst = 1'b0;
        waitT(5);
        chk("post reset br count", brCount, 4);
        data_to_send = 8'hE1;
        rxQ.push_back(8'hC3);
        startFrame();
        xfer(8'hC3, 8, 8'hE1, got);
        chk("post reset miso", got, 8'hE1);
        endFrame();
        chk("post reset br count", brCount, 5);
        chk("post reset received_data", received_data, 8'hC3);
        chk("scoreboard empty", rxQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
